gametank_ce_gen: RTL and testbench

- Parametrised, runtime-programmable clock-enable generator that sits directly behind the GameTank PLL.
- Derives NUM_CH fractional clock-enable pulse trains from one fast PLL clock using phase accumulators. This replaces fixed per-frequency PLL outputs and dividers.
- Gates everything on a debounced PLL lock and produces the sequenced downstream reset for the console core.
- Adds glitch-free frequency retune and phase-aligned resync, which the fixed PLL outputs cannot do.

---
 rtl/gametank_clk_pkg.sv | 21 ++
 rtl/gametank_ce_gen_if.sv | 28 ++
 rtl/gametank_ce_channel.sv | 82 ++++++++
 rtl/gametank_ce_gen.sv | 122 ++++++++++++
 tb/tb_gametank_ce_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gametank_clk_pkg.sv
// Shared types and defaults for the GameTank clock-enable generator.
// Holds the FSM state encoding, default parameter values and the channel-select width helper.
package gametank_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int          DEF_NUM_CH      = 3;
    localparam int          DEF_ACC_W       = 24;
    localparam logic [23:0] DEF_INC         = 24'h100000;
    localparam int          DEF_LOCK_CYCLES = 1024;
    localparam int          DEF_RST_HOLD    = 64;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gametank_ce_gen_if.sv
// Config/resync inputs and enable/reset outputs of the clock-enable generator.
// master = host side driving config, slave = the generator itself.
interface gametank_ce_gen_if #(
    parameter int NUM_CH = gametank_clk_pkg::DEF_NUM_CH,
    parameter int ACC_W  = gametank_clk_pkg::DEF_ACC_W
);
    localparam int CH_W = gametank_clk_pkg::ch_w(NUM_CH);

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              resync;
    logic [NUM_CH-1:0] ce_out;
    logic              rst_out_n;
    logic              running;

    modport master (
        output cfg_we, cfg_ch, cfg_inc, cfg_phase, resync,
        input  ce_out, rst_out_n, running
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_inc, cfg_phase, resync,
        output ce_out, rst_out_n, running
    );

endinterface

// File: rtl/gametank_ce_channel.sv
// One phase-accumulator channel: shadow/active inc+phase, carry-aligned retune, registered ce.
// ce is registered one edge after the carrying accumulation; no backpressure.
module gametank_ce_channel
    import gametank_clk_pkg::*;
#(
    parameter int               ACC_W       = DEF_ACC_W,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(DEF_INC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic [ACC_W-1:0] wr_phase,
    input  logic             load,
    input  logic             hold,
    input  logic             step,
    input  logic             resync,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_act_q, inc_act_d;
    logic [ACC_W-1:0] ph_act_q, ph_act_d;
    logic [ACC_W-1:0] inc_sh_q, inc_sh_d;
    logic [ACC_W-1:0] ph_sh_q, ph_sh_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum   = {1'b0, acc_q} + {1'b0, inc_act_q};
    assign carry = sum[ACC_W];
    assign ce    = ce_q;

    always_comb begin
        acc_d     = acc_q;
        inc_act_d = inc_act_q;
        ph_act_d  = ph_act_q;
        inc_sh_d  = inc_sh_q;
        ph_sh_d   = ph_sh_q;
        ce_d      = 1'b0;

        if (wr_en) begin
            inc_sh_d = wr_inc;
            ph_sh_d  = wr_phase;
        end

        // Shadow reads below use the pre-write values, so a same-cycle write lands one event later.
        if (load || resync) begin
            inc_act_d = inc_sh_q;
            ph_act_d  = ph_sh_q;
            acc_d     = ph_sh_q;
        end else if (hold) begin
            acc_d = ph_act_q;
        end else if (step) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = carry;
            // Retune only at a period boundary; a zero inc never carries, so it adopts at once.
            if (carry || (inc_act_q == '0)) begin
                inc_act_d = inc_sh_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            inc_act_q <= DEFAULT_INC;
            ph_act_q  <= '0;
            inc_sh_q  <= DEFAULT_INC;
            ph_sh_q   <= '0;
            ce_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            inc_act_q <= inc_act_d;
            ph_act_q  <= ph_act_d;
            inc_sh_q  <= inc_sh_d;
            ph_sh_q   <= ph_sh_d;
            ce_q      <= ce_d;
        end
    end

endmodule

// File: rtl/gametank_ce_gen.sv
// PLL-side clock-enable generator: lock qualification, sequenced downstream reset, NUM_CH fractional ce trains.
// rst_out_n rises 2+LOCK_CYCLES+RST_HOLD edges after pll_lock rises; no backpressure.
module gametank_ce_gen
    import gametank_clk_pkg::*;
#(
    parameter int               NUM_CH      = DEF_NUM_CH,
    parameter int               ACC_W       = DEF_ACC_W,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(DEF_INC),
    parameter int               LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int               RST_HOLD    = DEF_RST_HOLD
) (
    input logic               clk,
    input logic               reset_n,
    input logic               pll_lock,
    gametank_ce_gen_if.slave  bus
);

    localparam int CNT_MAX = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    logic              lock_m_q, lock_s_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rst_out_n_q, rst_out_n_d;
    logic              running_q, running_d;
    logic              enter_hold, hold_acc, do_step, do_resync;
    logic [NUM_CH-1:0] ce_w;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_hold = 1'b0;
        do_step    = 1'b0;
        do_resync  = 1'b0;

        // Lock loss overrides every state, including a pending resync.
        if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d    = HOLD;
                        cnt_d      = '0;
                        enter_hold = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    do_resync = bus.resync;
                    do_step   = !bus.resync;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end

        rst_out_n_d = (state_d == RUN);
        running_d   = (state_d == RUN);
    end

    assign hold_acc = (state_q == HOLD) && lock_s_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m_q    <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            rst_out_n_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            lock_m_q    <= pll_lock;
            lock_s_q    <= lock_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_n_q <= rst_out_n_d;
            running_q   <= running_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        // Out-of-range channel selects match no instance and are dropped.
        assign wr_en = bus.cfg_we && (int'(bus.cfg_ch) == i);

        gametank_ce_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (wr_en),
            .wr_inc   (bus.cfg_inc),
            .wr_phase (bus.cfg_phase),
            .load     (enter_hold),
            .hold     (hold_acc),
            .step     (do_step),
            .resync   (do_resync),
            .ce       (ce_w[i])
        );
    end

    assign bus.ce_out    = ce_w;
    assign bus.rst_out_n = rst_out_n_q;
    assign bus.running   = running_q;

endmodule

// File: tb/tb_gametank_ce_gen.sv
// Directed bench for gametank_ce_gen with ACC_W=8, LOCK_CYCLES=4, RST_HOLD=2, NUM_CH=3, DEFAULT_INC=8'h40.
// Lock-to-reset latency is exactly 8 edges counted from the first edge that samples pll_lock high.
module tb_gametank_ce_gen;

    logic clk;
    logic reset_n;
    logic pll_lock;

    int n_checks;
    int n_fail;
    logic [15:0] hist [3];
    logic [2:0]  ce_seen;

    gametank_ce_gen_if #(.NUM_CH(3), .ACC_W(8)) bus ();

    gametank_ce_gen #(
        .NUM_CH      (3),
        .ACC_W       (8),
        .DEFAULT_INC (8'h40),
        .LOCK_CYCLES (4),
        .RST_HOLD    (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pll_lock (pll_lock),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // hist[c][k] holds ce_out[c] after the k-th captured edge.
    task automatic capture(input int n);
        for (int c = 0; c < 3; c++) hist[c] = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            for (int c = 0; c < 3; c++) hist[c][k] = bus.ce_out[c];
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] inc, input logic [7:0] ph);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = ch;
        bus.cfg_inc   = inc;
        bus.cfg_phase = ph;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        pll_lock      = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_inc   = '0;
        bus.cfg_phase = '0;
        bus.resync    = 1'b0;

        repeat (3) tick();
        chk("reset_ce", 32'(bus.ce_out), 32'h0);
        chk("reset_rst_out_n", 32'(bus.rst_out_n), 32'h0);
        chk("reset_running", 32'(bus.running), 32'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        // First lock: 8 edges to RUN, no enables during the wait.
        pll_lock = 1'b1;
        ce_seen  = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            ce_seen |= bus.ce_out;
        end
        chk("lock_rst_before", 32'(bus.rst_out_n), 32'h0);
        tick();
        ce_seen |= bus.ce_out;
        chk("lock_ce_quiet", 32'(ce_seen), 32'h0);
        chk("lock_rst_after", 32'(bus.rst_out_n), 32'h1);
        chk("lock_running", 32'(bus.running), 32'h1);

        // Default inc 0x40: pulse on every 4th RUN edge.
        capture(8);
        chk("def_ch0", 32'(hist[0][7:0]), 32'h88);
        chk("def_ch1", 32'(hist[1][7:0]), 32'h88);
        chk("def_ch2", 32'(hist[2][7:0]), 32'h88);

        // ch2 inc=96 adopts at its next carry, then periods 3,3,2.
        cfg_write(2'd2, 8'd96, 8'd0);
        capture(12);
        chk("retune_ch2", 32'(hist[2][11:0]), 32'h524);
        chk("retune_ch0", 32'(hist[0][11:0]), 32'h444);

        cfg_write(2'd1, 8'd64, 8'd128);
        cfg_write(2'd0, 8'd64, 8'd0);
        bus.resync = 1'b1;
        tick();
        bus.resync = 1'b0;
        chk("resync_edge_ce", 32'(bus.ce_out), 32'h0);
        capture(8);
        chk("resync_ch0", 32'(hist[0][7:0]), 32'h88);
        chk("resync_ch1", 32'(hist[1][7:0]), 32'h22);
        chk("resync_ch2", 32'(hist[2][7:0]), 32'ha4);

        // Lock loss: outputs drop on the 3rd edge after the fall.
        pll_lock = 1'b0;
        tick();
        tick();
        chk("drop_running_d2", 32'(bus.running), 32'h1);
        tick();
        chk("drop_running_d3", 32'(bus.running), 32'h0);
        chk("drop_rst_d3", 32'(bus.rst_out_n), 32'h0);
        chk("drop_ce_d3", 32'(bus.ce_out), 32'h0);
        repeat (3) tick();

        // Relock with a one-cycle glitch after 3 highs: count restarts from the re-rise.
        pll_lock = 1'b1;
        repeat (3) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        ce_seen  = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            ce_seen |= bus.ce_out;
        end
        chk("glitch_rst_early", 32'(bus.rst_out_n), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            ce_seen |= bus.ce_out;
        end
        chk("glitch_rst_before", 32'(bus.rst_out_n), 32'h0);
        tick();
        ce_seen |= bus.ce_out;
        chk("glitch_ce_quiet", 32'(ce_seen), 32'h0);
        chk("glitch_rst_after", 32'(bus.rst_out_n), 32'h1);
        chk("glitch_running", 32'(bus.running), 32'h1);

        // Programmed inc/phase survive relock.
        capture(8);
        chk("relock_ch0", 32'(hist[0][7:0]), 32'h88);
        chk("relock_ch1", 32'(hist[1][7:0]), 32'h22);
        chk("relock_ch2", 32'(hist[2][7:0]), 32'ha4);

        cfg_write(2'd3, 8'd255, 8'd255);
        capture(8);
        chk("badch_ch0", 32'(hist[0][7:0]), 32'h44);
        chk("badch_ch1", 32'(hist[1][7:0]), 32'h11);
        chk("badch_ch2", 32'(hist[2][7:0]), 32'h52);

        // inc=0 takes over after one last carry, then silence.
        cfg_write(2'd0, 8'd0, 8'd0);
        capture(12);
        chk("inc0_ch0", 32'(hist[0][11:0]), 32'h002);

        cfg_write(2'd0, 8'd128, 8'd0);
        capture(6);
        chk("inc128_ch0", 32'(hist[0][5:0]), 32'h14);

        // Asynchronous reset clears outputs without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_running", 32'(bus.running), 32'h0);
        chk("arst_rst_out_n", 32'(bus.rst_out_n), 32'h0);
        chk("arst_ce", 32'(bus.ce_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
